// File: rtl/jtframe_cencross_strobes.sv
// Multi-channel strobe crossing into the cen domain, with per-channel pending counters,
// enforced low gap, sticky overflow and busy status. Define JTFRAME_CENCROSS_SYNC_EN for async stin.
module jtframe_cencross_strobes #(
  parameter int W    = 4,
  parameter int CNTW = 2,
  parameter int BOTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] stin,
  input  logic [W-1:0] ovf_clr,
  output logic [W-1:0] stout,
  output logic [W-1:0] busy,
  output logic [W-1:0] ovf
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [W-1:0]    st_s;
  logic [W-1:0]    last;
  logic [W-1:0]    ev;
  logic [W-1:0]    dec;
  logic [W-1:0]    sat;
  logic [W-1:0]    stout_nx;
  logic [W-1:0]    ovf_nx;
  logic [CNTW-1:0] cnt    [W];
  logic [CNTW-1:0] cnt_nx [W];

`ifdef JTFRAME_CENCROSS_SYNC_EN
  logic [W-1:0] sync0;
  logic [W-1:0] sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= stin;
      sync1 <= sync0;
    end
  end

  assign st_s = sync1;
`else
  assign st_s = stin;
`endif

  assign ev = (BOTH != 0) ? (st_s ^ last) : (st_s & ~last);

  always_comb begin
    dec      = '0;
    sat      = '0;
    stout_nx = stout;
    ovf_nx   = ovf;
    busy     = '0;
    for (int i = 0; i < W; i++) begin
      cnt_nx[i] = cnt[i];
      // a high stout always spends the next cen period low, so nothing is consumed then
      if (cen) begin
        if (stout[i]) begin
          stout_nx[i] = 1'b0;
        end else if (cnt[i] != '0 || ev[i]) begin
          stout_nx[i] = 1'b1;
          dec[i]      = 1'b1;
        end
      end
      if (ev[i] && !dec[i]) begin
        if (cnt[i] == CNT_MAX) sat[i] = 1'b1;
        else                   cnt_nx[i] = cnt[i] + CNTW'(1);
      end else if (dec[i] && !ev[i]) begin
        cnt_nx[i] = cnt[i] - CNTW'(1);
      end
      ovf_nx[i] = sat[i] | (ovf[i] & ~ovf_clr[i]);
      busy[i]   = (cnt[i] != '0) | stout[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= '0;
      stout <= '0;
      ovf   <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      last  <= st_s;
      stout <= stout_nx;
      ovf   <= ovf_nx;
      for (int i = 0; i < W; i++) cnt[i] <= cnt_nx[i];
    end
  end

endmodule
